ppm_decoder_param: RTL
======================

Name: ppm_decoder_param

Overview:
- Parametrised single-clock successor to the existing 1-of-4 PPM frame decoder.
- Decodes 1-of-2^BPS pulse-position-modulated serial data on din into DATA_W-bit words.
- Replaces the divided clock16 domain with an internal slot timer that re-aligns on every pulse edge.
- Adds frame-end pulse, frame byte count and coded error reporting; sits between the line receiver and the frame buffer.

Parameters:
- BPS, 2, bits per symbol (1..4); symbol window = 2^BPS slots.
- OSR, 16, clk cycles per slot (even, >=4).
- DATA_W, 8, output word width; must be a multiple of BPS.
- CNT_W, 8, width of frame word counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- din  in  1  asynchronous serial PPM line; idle low, pulse = high slot.
- dout  out  DATA_W  last decoded word; held until next word.
- d_en  out  1  one-cycle pulse, dout valid.
- f_en  out  1  one-cycle pulse on SOF accepted.
- f_end  out  1  one-cycle pulse on clean EOF.
- frm_len  out  CNT_W  words in current or last frame, saturating.
- err  out  1  one-cycle pulse on any error.
- err_code  out  2  01 multi-pulse window, 10 partial word at EOF, 11 SOF/run violation; held until next err.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs reset to 0; FSM resets to IDLE.
- Input conditioning:
  - din passes a 2-FF synchroniser, then rising-edge detect.
  - Phase counter runs 0..OSR-1. In IDLE it is held at 0 until a rising edge.
  - Any synced rising edge forces phase=0 in that cycle (resync).
  - sample_tick when phase==OSR/2; the sampled level is the slot value.
  - slot_tick when phase==OSR-1.
- SOF is exactly 3 consecutive high slots followed by 1 low slot. Data cannot contain more than 2 adjacent highs.
- EOF is a symbol window with no pulse.
- FSM states and transitions:
  - IDLE: wait for rising edge, then SOF_RUN with run count=1 at the first sample.
  - SOF_RUN: count high samples.
    - Low sample with run==3: go to SOF_GAP.
    - Low sample with run<3: back to IDLE silently.
    - Run reaches 4: err, code 11, go to IDLE.
  - SOF_GAP: this is the low slot just sampled. At its slot_tick: f_en pulse, frm_len cleared, symbol/slot indices cleared, go to DATA.
  - DATA: slot index i runs 0..2^BPS-1.
    - Record the pulse position and count highs within the window.
    - Window end (sample of slot 2^BPS-1) with exactly one high: symbol = position.
    - Window end with zero highs: EOF.
      - Symbol index within word = 0: f_end pulse.
      - Otherwise: err, code 10; partial word discarded, no d_en.
      - Either way, go to IDLE.
    - Second high in a window: err, code 01, immediate abort to IDLE. No f_end; frm_len keeps its value.
- Word assembly:
  - Symbols are packed LSB-first: first symbol goes to bits [BPS-1:0].
  - After DATA_W/BPS symbols, dout is loaded and d_en pulses.
- Latency and counting:
  - d_en and f_end assert 1 clk after the sample_tick of the window's last slot.
  - err asserts 1 clk after the offending sample.
  - frm_len increments with each d_en and saturates at 2^CNT_W-1; no wrap, no error.
- Simultaneous events:
  - A rising edge coinciding with sample_tick: the resync wins, so no sample is taken that cycle.
  - A word completing in the same window as an error cannot occur, because the error aborts before the window end.
- rst_n asserted mid-frame: immediate return to IDLE. Outputs clear and no pulses are generated.

Decomposition:
- Package ppm_pkg holds:
  - the FSM state enum (IDLE, SOF_RUN, SOF_GAP, DATA);
  - err_code constants ERR_MULTI=2'b01, ERR_PARTIAL=2'b10, ERR_RUN=2'b11;
  - the SOF_RUN_LEN=3 constant.
- One sub-module, ppm_slot_timer: synchroniser, edge detect and phase counter; outputs sample_tick, slot_tick, sample_val, rise.
- The top holds the FSM, the shift/pack register and the counters.

Test Plan:
- BPS=2, OSR=16: SOF, then slot positions 1,1,2,2, then empty window -> f_en, then d_en with dout=0xA5, then f_end; frm_len=1, err never.
- SOF plus 3 words 0x00, 0xFF, 0x3C then EOF -> three d_en in order, f_end, frm_len=3.
- Window with pulses in slots 0 and 2 after SOF -> err with code 01, no d_en or f_end, FSM back to IDLE; a following valid frame decodes correctly.
- SOF, 2 symbols, then empty window -> err with code 10, no d_en.
- din high for 4 slots -> err with code 11. A 2-slot high run -> silent return to IDLE, no f_en.
- Jitter: pulse edges shifted ±OSR/4 cycles each symbol -> word still decodes correctly.
- rst_n pulsed mid-word -> all outputs 0; the next frame decodes correctly.
- CNT_W=2 with 5 words -> frm_len saturates at 3.
- BPS=1, DATA_W=4 with word 0x9 -> d_en with dout=0x9.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared types and constants for the parametrised PPM frame decoder.
package ppm_pkg;
    typedef enum logic [1:0] {IDLE, SOF_RUN, SOF_GAP, DATA} state_t;

    localparam logic [1:0] ERR_MULTI   = 2'b01;
    localparam logic [1:0] ERR_PARTIAL = 2'b10;
    localparam logic [1:0] ERR_RUN     = 2'b11;

    localparam int SOF_RUN_LEN = 3;
endpackage

// File: rtl/ppm_slot_timer.sv
// Line synchroniser, rising-edge detect and slot phase counter that
// re-aligns to every pulse edge.
module ppm_slot_timer #(
    parameter int OSR = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic hold,
    output logic sample_tick,
    output logic slot_tick,
    output logic sample_val,
    output logic rise
);
    localparam int PW = $clog2(OSR);

    logic [2:0]    sync;
    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[1:0], din};
    end

    assign sample_val  = sync[1];
    assign rise        = sync[1] & ~sync[2];
    assign sample_tick = !rise && (phase == PW'(OSR/2));
    // An early edge arriving after the sample point closes the current slot,
    // so the slot index still advances when a pulse is pulled forward.
    assign slot_tick   = rise ? (phase > PW'(OSR/2)) : (phase == PW'(OSR-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      phase <= '0;
        else if (rise)                   phase <= PW'(1);
        else if (hold)                   phase <= '0;
        else if (phase == PW'(OSR-1))    phase <= '0;
        else                             phase <= phase + 1'b1;
    end
endmodule

// File: rtl/ppm_decoder_param.sv
// 1-of-2^BPS PPM frame decoder: SOF detection, symbol capture, LSB-first word
// packing, frame length counting and coded error reporting.
module ppm_decoder_param
    import ppm_pkg::*;
#(
    parameter int BPS    = 2,
    parameter int OSR    = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              d_en,
    output logic              f_en,
    output logic              f_end,
    output logic [CNT_W-1:0]  frm_len,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int NSYM = DATA_W / BPS;
    localparam int SIW  = (NSYM > 1) ? $clog2(NSYM) : 1;

    state_t            state, state_d;
    logic              sample_tick, slot_tick, sample_val, rise, idle;
    logic [2:0]        run;
    logic [BPS-1:0]    slot, pos, sym;
    logic              hit;
    logic [SIW-1:0]    sidx;
    logic [DATA_W-1:0] shreg, word_d;
    logic              sof_ev, sym_ev, eof_ok, err_ev, word_done;
    logic [1:0]        code_d;

    assign idle = (state == IDLE);

    ppm_slot_timer #(.OSR(OSR)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .hold        (idle),
        .sample_tick (sample_tick),
        .slot_tick   (slot_tick),
        .sample_val  (sample_val),
        .rise        (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        sof_ev  = 1'b0;
        sym_ev  = 1'b0;
        eof_ok  = 1'b0;
        err_ev  = 1'b0;
        code_d  = ERR_MULTI;
        sym     = hit ? pos : slot;
        case (state)
            IDLE: if (rise) state_d = SOF_RUN;
            SOF_RUN: if (sample_tick) begin
                if (sample_val) begin
                    if (run == 3'(SOF_RUN_LEN)) begin
                        err_ev  = 1'b1;
                        code_d  = ERR_RUN;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = (run == 3'(SOF_RUN_LEN)) ? SOF_GAP : IDLE;
                end
            end
            SOF_GAP: if (slot_tick) begin
                sof_ev  = 1'b1;
                state_d = DATA;
            end
            DATA: if (sample_tick) begin
                if (sample_val && hit) begin
                    err_ev  = 1'b1;
                    code_d  = ERR_MULTI;
                    state_d = IDLE;
                end else if (slot == '1) begin
                    if (hit || sample_val) begin
                        sym_ev = 1'b1;
                    end else if (sidx == '0) begin
                        eof_ok  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_ev  = 1'b1;
                        code_d  = ERR_PARTIAL;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d = shreg;
        word_d[sidx*BPS +: BPS] = sym;
    end

    assign word_done = sym_ev && (sidx == SIW'(NSYM-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            d_en     <= 1'b0;
            f_en     <= 1'b0;
            f_end    <= 1'b0;
            frm_len  <= '0;
            err      <= 1'b0;
            err_code <= '0;
            run      <= '0;
            slot     <= '0;
            pos      <= '0;
            hit      <= 1'b0;
            sidx     <= '0;
            shreg    <= '0;
        end else begin
            d_en  <= 1'b0;
            f_en  <= sof_ev;
            f_end <= eof_ok;
            err   <= err_ev;
            if (err_ev) err_code <= code_d;

            if (idle)                                           run <= '0;
            else if (state == SOF_RUN && sample_tick && sample_val) run <= run + 3'd1;

            if (sof_ev) begin
                slot    <= '0;
                hit     <= 1'b0;
                sidx    <= '0;
                frm_len <= '0;
            end else if (state == DATA) begin
                if (slot_tick) slot <= slot + 1'b1;
                if (sample_tick) begin
                    if (slot == '1) hit <= 1'b0;
                    else if (sample_val) begin
                        hit <= 1'b1;
                        pos <= slot;
                    end
                end
                if (sym_ev) begin
                    if (word_done) begin
                        dout <= word_d;
                        d_en <= 1'b1;
                        sidx <= '0;
                        if (frm_len != '1) frm_len <= frm_len + 1'b1;
                    end else begin
                        shreg <= word_d;
                        sidx  <= sidx + 1'b1;
                    end
                end
            end
        end
    end
endmodule
